// File: rtl/demux_skid_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer and its per-channel skid FIFOs.
package demux_skid_pkg;
  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_DEPTH = 2;
  localparam int NUM_CH      = 2;
  // Occupancy counter must represent 0..DEMUX_DEPTH inclusive.
  localparam int CNT_W       = $clog2(DEMUX_DEPTH + 1);
endpackage

// File: rtl/demux_skid_ch.sv
// One output channel: 2-entry FIFO with registered occupancy and a valid/ready output.
module demux_skid_ch
  import demux_skid_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic [WIDTH-1:0] r_mem [DEMUX_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full      = (r_count == CNT_W'(DEMUX_DEPTH));
  assign o_out_valid = (r_count != '0);
  // Held data is hidden while empty so a stale word never shows on the bus.
  assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = i_push & ~o_full;
  assign w_pop  = o_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/demux_skid.sv
// Registered 1-to-2 demultiplexer: steers each accepted word by in_sel into one of two skid FIFOs.
module demux_skid
  import demux_skid_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and in_ready depends only on in_sel and registered
  // occupancy, so a consumer's ready never reaches the producer combinationally.
  logic [NUM_CH-1:0] w_full;
  logic              w_accept;
  logic              w_push0;
  logic              w_push1;

  assign in_ready = in_sel ? ~w_full[1] : ~w_full[0];
  assign w_accept = in_valid & in_ready;
  assign w_push0  = w_accept & ~in_sel;
  assign w_push1  = w_accept &  in_sel;

  demux_skid_ch #(.WIDTH(WIDTH)) u_ch0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push0),
    .i_push_data (in_data),
    .o_full      (w_full[0]),
    .o_out_data  (out0_data),
    .o_out_valid (out0_valid),
    .i_out_ready (out0_ready)
  );

  demux_skid_ch #(.WIDTH(WIDTH)) u_ch1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push1),
    .i_push_data (in_data),
    .o_full      (w_full[1]),
    .o_out_data  (out1_data),
    .o_out_valid (out1_valid),
    .i_out_ready (out1_ready)
  );

endmodule
